// File: rtl/feature_bank_scheduler_if.sv
// Handshake bundle between the ping-pong feature bank scheduler and its
// fetcher/shifter clients. The scheduler uses the slave modport.
interface feature_bank_scheduler_if #(
  parameter int LINE_CNT_WIDTH = 8,
  parameter int STAT_WIDTH     = 16
);
  logic                      wr_req;
  logic                      wr_grant;
  logic                      wr_bank;
  logic                      wr_done;
  logic [LINE_CNT_WIDTH-1:0] wr_line_cnt;
  logic                      rd_req;
  logic                      rd_grant;
  logic                      rd_bank;
  logic [LINE_CNT_WIDTH-1:0] rd_line_cnt;
  logic                      rd_done;
  logic [1:0]                bank_full;
  logic [1:0]                bank_empty;
  logic                      proto_err;
  logic [STAT_WIDTH-1:0]     wr_stall_cnt;
  logic [STAT_WIDTH-1:0]     rd_stall_cnt;

  modport master (
    output wr_req, wr_done, wr_line_cnt, rd_req, rd_done,
    input  wr_grant, wr_bank, rd_grant, rd_bank, rd_line_cnt,
           bank_full, bank_empty, proto_err, wr_stall_cnt, rd_stall_cnt
  );

  modport slave (
    input  wr_req, wr_done, wr_line_cnt, rd_req, rd_done,
    output wr_grant, wr_bank, rd_grant, rd_bank, rd_line_cnt,
           bank_full, bank_empty, proto_err, wr_stall_cnt, rd_stall_cnt
  );
endinterface

// File: rtl/feature_bank_scheduler.sv
// Ping-pong scheduler for the two scratchpad feature banks; reads follow write order.
// Optional stall statistics are built only when FEATURE_BANK_STATS_EN is defined.
module feature_bank_scheduler #(
  parameter int LINE_CNT_WIDTH = 8,
  parameter int STAT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  feature_bank_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  bank_state_e               bank_state_r  [2];
  bank_state_e               bank_state_nx_s [2];
  logic [LINE_CNT_WIDTH-1:0] line_cnt_r    [2];
  logic [LINE_CNT_WIDTH-1:0] line_cnt_nx_s [2];
  logic                      wr_ptr_r;
  logic                      rd_ptr_r;
  logic                      wr_active_r;
  logic                      rd_active_r;
  logic                      wr_grant_s;
  logic                      rd_grant_s;
  logic                      wr_done_ok_s;
  logic                      rd_done_ok_s;
  logic                      proto_hit_s;
  logic [1:0]                bank_full_nx_s;
  logic [1:0]                bank_empty_nx_s;
  logic                      wr_grant_r;
  logic                      wr_bank_r;
  logic                      rd_grant_r;
  logic                      rd_bank_r;
  logic [LINE_CNT_WIDTH-1:0] rd_line_cnt_r;
  logic [1:0]                bank_full_r;
  logic [1:0]                bank_empty_r;
  logic                      proto_err_r;

  // Grant qualification and per-bank next-state decode from registered state only.
  always_comb begin
    wr_grant_s      = bus.wr_req && !wr_active_r && (bank_state_r[wr_ptr_r] == EMPTY);
    rd_grant_s      = bus.rd_req && !rd_active_r && (bank_state_r[rd_ptr_r] == FULL);
    wr_done_ok_s    = bus.wr_done && wr_active_r;
    rd_done_ok_s    = bus.rd_done && rd_active_r;
    proto_hit_s     = (bus.wr_done && !wr_active_r) || (bus.rd_done && !rd_active_r);
    bank_full_nx_s  = 2'b00;
    bank_empty_nx_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      bank_state_nx_s[i] = bank_state_r[i];
      line_cnt_nx_s[i]   = line_cnt_r[i];
      case (bank_state_r[i])
        EMPTY: begin
          if (wr_grant_s && (wr_ptr_r == i[0])) bank_state_nx_s[i] = FILLING;
          else                                  bank_state_nx_s[i] = EMPTY;
        end
        FILLING: begin
          if (wr_done_ok_s && (wr_ptr_r == i[0])) begin
            bank_state_nx_s[i] = FULL;
            line_cnt_nx_s[i]   = bus.wr_line_cnt;
          end else begin
            bank_state_nx_s[i] = FILLING;
          end
        end
        FULL: begin
          if (rd_grant_s && (rd_ptr_r == i[0])) bank_state_nx_s[i] = DRAINING;
          else                                  bank_state_nx_s[i] = FULL;
        end
        DRAINING: begin
          if (rd_done_ok_s && (rd_ptr_r == i[0])) bank_state_nx_s[i] = EMPTY;
          else                                    bank_state_nx_s[i] = DRAINING;
        end
        default: bank_state_nx_s[i] = EMPTY;
      endcase
      bank_full_nx_s[i]  = (bank_state_nx_s[i] == FULL);
      bank_empty_nx_s[i] = (bank_state_nx_s[i] == EMPTY);
    end
  end

  // State, pointer and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        bank_state_r[i] <= EMPTY;
        line_cnt_r[i]   <= {LINE_CNT_WIDTH{1'b0}};
      end
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      wr_active_r   <= 1'b0;
      rd_active_r   <= 1'b0;
      wr_grant_r    <= 1'b0;
      wr_bank_r     <= 1'b0;
      rd_grant_r    <= 1'b0;
      rd_bank_r     <= 1'b0;
      rd_line_cnt_r <= {LINE_CNT_WIDTH{1'b0}};
      bank_full_r   <= 2'b00;
      bank_empty_r  <= 2'b11;
      proto_err_r   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        bank_state_r[i] <= bank_state_nx_s[i];
        line_cnt_r[i]   <= line_cnt_nx_s[i];
      end
      wr_grant_r   <= wr_grant_s;
      rd_grant_r   <= rd_grant_s;
      bank_full_r  <= bank_full_nx_s;
      bank_empty_r <= bank_empty_nx_s;
      if (wr_done_ok_s) wr_ptr_r <= ~wr_ptr_r;
      else              wr_ptr_r <= wr_ptr_r;
      if (rd_done_ok_s) rd_ptr_r <= ~rd_ptr_r;
      else              rd_ptr_r <= rd_ptr_r;
      if (wr_grant_s)        wr_active_r <= 1'b1;
      else if (wr_done_ok_s) wr_active_r <= 1'b0;
      else                   wr_active_r <= wr_active_r;
      if (rd_grant_s)        rd_active_r <= 1'b1;
      else if (rd_done_ok_s) rd_active_r <= 1'b0;
      else                   rd_active_r <= rd_active_r;
      // Bank select and line count stay valid until the next grant.
      if (wr_grant_s) wr_bank_r <= wr_ptr_r;
      else            wr_bank_r <= wr_bank_r;
      if (rd_grant_s) begin
        rd_bank_r     <= rd_ptr_r;
        rd_line_cnt_r <= line_cnt_r[rd_ptr_r];
      end else begin
        rd_bank_r     <= rd_bank_r;
        rd_line_cnt_r <= rd_line_cnt_r;
      end
      if (proto_hit_s) proto_err_r <= 1'b1;
      else             proto_err_r <= proto_err_r;
    end
  end

  assign bus.wr_grant    = wr_grant_r;
  assign bus.wr_bank     = wr_bank_r;
  assign bus.rd_grant    = rd_grant_r;
  assign bus.rd_bank     = rd_bank_r;
  assign bus.rd_line_cnt = rd_line_cnt_r;
  assign bus.bank_full   = bank_full_r;
  assign bus.bank_empty  = bank_empty_r;
  assign bus.proto_err   = proto_err_r;

`ifdef FEATURE_BANK_STATS_EN
  logic [STAT_WIDTH-1:0] wr_stall_r;
  logic [STAT_WIDTH-1:0] rd_stall_r;

  // Saturating count of cycles a requester waits without being granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_stall_r <= {STAT_WIDTH{1'b0}};
      rd_stall_r <= {STAT_WIDTH{1'b0}};
    end else begin
      if (bus.wr_req && !wr_active_r && !wr_grant_s && (wr_stall_r != {STAT_WIDTH{1'b1}}))
        wr_stall_r <= wr_stall_r + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
      else
        wr_stall_r <= wr_stall_r;
      if (bus.rd_req && !rd_active_r && !rd_grant_s && (rd_stall_r != {STAT_WIDTH{1'b1}}))
        rd_stall_r <= rd_stall_r + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
      else
        rd_stall_r <= rd_stall_r;
    end
  end

  assign bus.wr_stall_cnt = wr_stall_r;
  assign bus.rd_stall_cnt = rd_stall_r;
`else
  assign bus.wr_stall_cnt = {STAT_WIDTH{1'b0}};
  assign bus.rd_stall_cnt = {STAT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_feature_bank_scheduler.sv
// Directed bench for feature_bank_scheduler: a cycle table for the main ping-pong
// flow plus hand sequences for stalls, same-cycle hazards, protocol errors and async reset.
module tb_feature_bank_scheduler;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  feature_bank_scheduler_if #(.LINE_CNT_WIDTH(8), .STAT_WIDTH(16)) bus ();

  feature_bank_scheduler #(.LINE_CNT_WIDTH(8), .STAT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr_req;
    logic       wr_done;
    logic [7:0] wcnt;
    logic       rd_req;
    logic       rd_done;
    logic       wg;
    logic       wb;
    logic       rg;
    logic       rb;
    logic [7:0] rcnt;
    logic [1:0] full;
    logic [1:0] empty;
    logic       perr;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_req = 1'b0; bus.wr_done = 1'b0; bus.wr_line_cnt = 8'd0;
    bus.rd_req = 1'b0; bus.rd_done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_wg"},    32'(bus.wr_grant),     32'd0);
    chk({tag, "_wb"},    32'(bus.wr_bank),      32'd0);
    chk({tag, "_rg"},    32'(bus.rd_grant),     32'd0);
    chk({tag, "_rb"},    32'(bus.rd_bank),      32'd0);
    chk({tag, "_rcnt"},  32'(bus.rd_line_cnt),  32'd0);
    chk({tag, "_full"},  32'(bus.bank_full),    32'd0);
    chk({tag, "_empty"}, 32'(bus.bank_empty),   32'd3);
    chk({tag, "_perr"},  32'(bus.proto_err),    32'd0);
    chk({tag, "_wst"},   32'(bus.wr_stall_cnt), 32'd0);
    chk({tag, "_rst"},   32'(bus.rd_stall_cnt), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_stall;
    tests = 0;
    fails = 0;
`ifdef FEATURE_BANK_STATS_EN
    exp_stall = 32'd5;
`else
    exp_stall = 32'd0;
`endif
    //           wreq  wdone wcnt   rreq  rdone  wg    wb    rg    rb    rcnt   full   empty  perr
    vecs[0]  = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  2'b00, 2'b11, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  2'b00, 2'b10, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  2'b00, 2'b10, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  2'b01, 2'b10, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  2'b01, 2'b00, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'd9,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd12, 2'b10, 2'b00, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd12, 2'b10, 2'b00, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd12, 2'b10, 2'b01, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd9,  2'b00, 2'b00, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd9,  2'b00, 2'b00, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd9,  2'b01, 2'b00, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd9,  2'b01, 2'b10, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  2'b00, 2'b10, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  2'b00, 2'b11, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  2'b00, 2'b11, 1'b0};

    do_reset();
    chk_reset_values("reset");

    // Main ping-pong flow, one record per clock.
    for (int i = 0; i < 15; i++) begin
      bus.wr_req      = vecs[i].wr_req;
      bus.wr_done     = vecs[i].wr_done;
      bus.wr_line_cnt = vecs[i].wcnt;
      bus.rd_req      = vecs[i].rd_req;
      bus.rd_done     = vecs[i].rd_done;
      tick();
      chk($sformatf("v%0d_wg", i),    32'(bus.wr_grant),    32'(vecs[i].wg));
      chk($sformatf("v%0d_wb", i),    32'(bus.wr_bank),     32'(vecs[i].wb));
      chk($sformatf("v%0d_rg", i),    32'(bus.rd_grant),    32'(vecs[i].rg));
      chk($sformatf("v%0d_rb", i),    32'(bus.rd_bank),     32'(vecs[i].rb));
      chk($sformatf("v%0d_rcnt", i),  32'(bus.rd_line_cnt), 32'(vecs[i].rcnt));
      chk($sformatf("v%0d_full", i),  32'(bus.bank_full),   32'(vecs[i].full));
      chk($sformatf("v%0d_empty", i), 32'(bus.bank_empty),  32'(vecs[i].empty));
      chk($sformatf("v%0d_perr", i),  32'(bus.proto_err),   32'(vecs[i].perr));
    end
    bus.wr_req = 1'b0; bus.wr_done = 1'b0; bus.rd_req = 1'b0; bus.rd_done = 1'b0;

    // Both banks full: writer stalls, then gets bank 0 two cycles after rd_done.
    do_reset();
    bus.wr_req = 1'b1; tick(); bus.wr_req = 1'b0;
    chk("a_grant0", 32'(bus.wr_grant), 32'd1);
    bus.wr_done = 1'b1; bus.wr_line_cnt = 8'd12; tick(); bus.wr_done = 1'b0;
    chk("a_full0", 32'(bus.bank_full), 32'd1);
    bus.wr_req = 1'b1; tick(); bus.wr_req = 1'b0;
    chk("a_grant1_bank", 32'(bus.wr_bank), 32'd1);
    bus.wr_done = 1'b1; bus.wr_line_cnt = 8'd9; tick(); bus.wr_done = 1'b0;
    chk("a_full_both", 32'(bus.bank_full), 32'd3);
    bus.wr_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("a_stall_nogrant%0d", k), 32'(bus.wr_grant), 32'd0);
    end
    chk("a_wr_stall_cnt", 32'(bus.wr_stall_cnt), exp_stall);
    bus.rd_req = 1'b1; tick(); bus.rd_req = 1'b0;
    chk("a_rg", 32'(bus.rd_grant), 32'd1);
    chk("a_rb", 32'(bus.rd_bank), 32'd0);
    chk("a_rcnt", 32'(bus.rd_line_cnt), 32'd12);
    bus.rd_done = 1'b1; tick(); bus.rd_done = 1'b0;
    chk("a_wg_after1", 32'(bus.wr_grant), 32'd0);
    tick();
    chk("a_wg_after2", 32'(bus.wr_grant), 32'd1);
    chk("a_wb_after2", 32'(bus.wr_bank), 32'd0);
    bus.wr_req = 1'b0;

    // wr_done and rd_req on the same bank in one cycle: read grant waits a cycle.
    do_reset();
    bus.wr_req = 1'b1; tick(); bus.wr_req = 1'b0;
    bus.wr_done = 1'b1; bus.wr_line_cnt = 8'd7; bus.rd_req = 1'b1;
    tick(); bus.wr_done = 1'b0;
    chk("b_rg_n1", 32'(bus.rd_grant), 32'd0);
    chk("b_full_n1", 32'(bus.bank_full), 32'd1);
    tick(); bus.rd_req = 1'b0;
    chk("b_rg_n2", 32'(bus.rd_grant), 32'd1);
    chk("b_rb_n2", 32'(bus.rd_bank), 32'd0);
    chk("b_rcnt_n2", 32'(bus.rd_line_cnt), 32'd7);

    // Spurious rd_done while bank 1 is filling.
    bus.rd_done = 1'b1; tick(); bus.rd_done = 1'b0;
    chk("c_empty_drained", 32'(bus.bank_empty), 32'd3);
    bus.wr_req = 1'b1; tick(); bus.wr_req = 1'b0;
    chk("c_wg", 32'(bus.wr_grant), 32'd1);
    chk("c_wb", 32'(bus.wr_bank), 32'd1);
    chk("c_empty_fill", 32'(bus.bank_empty), 32'd1);
    bus.rd_done = 1'b1; tick(); bus.rd_done = 1'b0;
    chk("c_perr", 32'(bus.proto_err), 32'd1);
    chk("c_empty_keep", 32'(bus.bank_empty), 32'd1);
    chk("c_full_keep", 32'(bus.bank_full), 32'd0);
    tick();
    chk("c_perr_sticky", 32'(bus.proto_err), 32'd1);

    // Asynchronous reset mid-fill, observed before the next clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk_reset_values("async");
    #1;
    rst = 1'b0;
    tick();
    chk("post_reset_empty", 32'(bus.bank_empty), 32'd3);
    chk("post_reset_perr", 32'(bus.proto_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/feature_bank_scheduler.md
Name: feature_bank_scheduler

Overview:
- Owns the ping-pong pair of scratchpad feature memory groups (bank 0, bank 1).
- Grants banks to the input feature fetcher (writer) and to the vertical register shifter (reader).
- Tracks each bank as EMPTY, FILLING, FULL or DRAINING, so compute never reads a half-written tile and the fetcher never overwrites an unconsumed one.
- Reads are served strictly in write order.

Parameters:
- LINE_CNT_WIDTH, 8: width of the per-bank valid-line count.
- STAT_WIDTH, 16: width of the saturating stall counters (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- wr_req  in  1  fetcher requests a bank for a new tile (level).
- wr_grant  out  1  one-cycle grant pulse to the fetcher.
- wr_bank  out  1  bank the fetcher must write; valid from grant until wr_done.
- wr_done  in  1  pulse: fetcher finished filling the granted bank.
- wr_line_cnt  in  LINE_CNT_WIDTH  lines written; sampled on wr_done.
- rd_req  in  1  shifter requests a full bank (level).
- rd_grant  out  1  one-cycle grant pulse to the shifter.
- rd_bank  out  1  bank the shifter must read; drives the feature_en_0/1 select.
- rd_line_cnt  out  LINE_CNT_WIDTH  valid lines in the granted bank.
- rd_done  in  1  pulse: shifter finished consuming the granted bank.
- bank_full  out  2  bit i = bank i is FULL.
- bank_empty  out  2  bit i = bank i is EMPTY.
- proto_err  out  1  sticky protocol error flag.
- wr_stall_cnt  out  STAT_WIDTH  optional-feature counter.
- rd_stall_cnt  out  STAT_WIDTH  optional-feature counter.

Behaviour:
- Reset (async, rst=1): all outputs go to 0 except bank_empty=2'b11.
  - Both banks EMPTY; wr_ptr=0, rd_ptr=0; wr_active=0, rd_active=0; line counts 0.
- Per-bank state machine, 2-bit encoding:
  - EMPTY -> FILLING on write grant.
  - FILLING -> FULL on wr_done; the line count is captured.
  - FULL -> DRAINING on read grant.
  - DRAINING -> EMPTY on rd_done.
- Write grant:
  - Condition: wr_req=1, wr_active=0, bank[wr_ptr]==EMPTY at edge N.
  - Result at N+1: wr_grant=1 for one cycle, wr_bank=wr_ptr, wr_active=1, bank FILLING.
  - wr_ptr toggles at wr_done, not at grant.
  - wr_req is ignored while wr_active=1; the requester drops it on seeing the grant.
- Read grant:
  - Condition: rd_req=1, rd_active=0, bank[rd_ptr]==FULL at edge N.
  - Result at N+1: rd_grant=1 for one cycle, rd_bank=rd_ptr, rd_line_cnt=count[rd_ptr], rd_active=1.
  - rd_ptr toggles at rd_done.
- Ordering: the writer only ever uses bank wr_ptr and the reader bank rd_ptr, both alternating. A free non-pointer bank is never granted out of order.
- wr_bank, rd_bank and rd_line_cnt hold their value after done until the next grant.
- Grant latency is exactly 1 cycle from the qualifying edge. Status decisions use registered state only.
- Simultaneous events:
  - wr_done and rd_req for the same bank in one cycle: the bank becomes FULL at N+1; rd_grant at N+2 at the earliest.
  - rd_done and wr_req for the same bank in one cycle: the bank becomes EMPTY at N+1; wr_grant at N+2.
  - Write and read grants to different banks may fire in the same cycle.
- wr_line_cnt=0 is legal: the bank goes FULL with count 0 and is granted normally.
- Protocol errors: wr_done with wr_active=0, or rd_done with rd_active=0.
  - The pulse is ignored and proto_err is set; it clears only on reset.
- Reset mid-operation: all state is discarded immediately; any in-flight tile is lost. Requesters must restart after reset.

Optional Feature:
- Macro: FEATURE_BANK_STATS_EN.
- Defined:
  - wr_stall_cnt increments each cycle wr_req=1 && wr_active=0 && no write grant is issued.
  - rd_stall_cnt is the same for the read side.
  - Both saturate at all-ones and reset to 0.
- Undefined: both ports are tied to 0 and no counter logic is generated.
- Grant behaviour is identical in both builds.

Test Plan:
- Reset, then wr_req at cycle 2 -> wr_grant pulse at cycle 3, wr_bank=0, bank_empty=2'b10.
  - Then wr_done with wr_line_cnt=12 -> bank_full=2'b01.
- Fill both banks (counts 12, 9), then rd_req held -> rd_grant with rd_bank=0, rd_line_cnt=12.
  - After rd_done, next rd_grant gives rd_bank=1, rd_line_cnt=9 (order preserved).
- Both banks FULL, wr_req held 5 cycles -> no wr_grant; wr_stall_cnt=5 with macro (0 without).
  - rd_done on bank 0 -> wr_grant 2 cycles later with wr_bank=0.
- wr_done and rd_req in the same cycle on bank 0 -> rd_grant exactly 2 cycles later, not 1.
- Spurious rd_done with no read active -> proto_err=1, all bank states unchanged.
  - rst asserted mid-FILLING -> all outputs return to reset values asynchronously; bank_empty=2'b11.
